bht_branch_controller: RTL and testbench

- Dynamic branch-prediction controller for the LC-3b pipeline. It sits between fetch and execute and replaces static "always-taken" prediction with a table of 2-bit saturating counters.
- It tracks every outstanding predicted BR in a small in-order queue and checks each one against the execute-stage resolution.
- On a mispredict it issues a one-cycle registered flush with the corrected PC.
- It also stalls fetch when the queue is full and counts mispredicts.

---
 rtl/bht_branch_controller.sv | 114 +++++++++++
 tb/tb_bht_branch_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bht_branch_controller.sv
// Dynamic branch predictor for the LC-3b pipeline. A table of 2-bit saturating
// counters predicts BR direction. An in-order queue holds the outstanding
// predictions and checks each one against the execute-stage resolution.
// A mispredict raises a registered one-cycle flush that carries the corrected PC.
module bht_branch_controller #(
   parameter int IDX_BITS = 5,
   parameter int DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_valid,
   input  logic [15:0] ir,
   input  logic [15:0] pc,
   output logic        fetch_ready,
   output logic        sel_branch_predict,
   output logic [15:0] branch_target,
   input  logic        resolve_valid,
   input  logic        resolve_taken,
   input  logic [15:0] resolve_next_pc,
   output logic        flush,
   output logic [15:0] flush_pc,
   output logic [15:0] mispredict_count
);

   localparam int unsigned    ENTRIES   = 1 << IDX_BITS;
   localparam int             PTR_BITS  = $clog2(DEPTH);
   localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS + 1)'(DEPTH);
   localparam logic [3:0]     OP_BR     = 4'b0000;

   logic [1:0]          ctr     [ENTRIES];
   logic [IDX_BITS-1:0] q_idx   [DEPTH];
   logic                q_taken [DEPTH];
   logic [15:0]         q_npc   [DEPTH];

   logic [PTR_BITS-1:0] head, tail;
   logic [PTR_BITS:0]   count;

   logic                is_br, pred_taken, full, empty, push, pop, mispredict;
   logic [IDX_BITS-1:0] idx, head_idx;
   logic [15:0]         pred_next_pc;

   // Decode, table lookup and queue handshake for the current cycle
   always_comb begin
      is_br              = (ir[15:12] == OP_BR) && (ir[11:9] != 3'b000);
      idx                = pc[IDX_BITS:1];
      pred_taken         = (ir[11:9] == 3'b111) || ctr[idx][1];
      branch_target      = pc + {{6{ir[8]}}, ir[8:0], 1'b0};
      pred_next_pc       = pred_taken ? branch_target : pc;
      full               = (count == DEPTH_CNT);
      empty              = (count == '0);
      fetch_ready        = !full && !flush;
      push               = fetch_valid && fetch_ready && is_br;
      sel_branch_predict = push && pred_taken;
      pop                = resolve_valid && !empty && !flush;
      head_idx           = q_idx[head];
      mispredict         = pop && ((resolve_taken != q_taken[head]) ||
                                   (resolve_next_pc != q_npc[head]));
   end

   // Saturating counter training on every resolved branch
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++)
            ctr[IDX_BITS'(i)] <= 2'b01;
      end else if (pop) begin
         if (resolve_taken && ctr[head_idx] != 2'b11)
            ctr[head_idx] <= ctr[head_idx] + 2'd1;
         else if (!resolve_taken && ctr[head_idx] != 2'b00)
            ctr[head_idx] <= ctr[head_idx] - 2'd1;
      end
   end

   // Queue payload write; a discarded push only writes an entry that the clear makes dead
   always_ff @(posedge clk) begin
      if (push) begin
         q_idx[tail]   <= idx;
         q_taken[tail] <= pred_taken;
         q_npc[tail]   <= pred_next_pc;
      end
   end

   // Queue pointers, flush generation and mispredict statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         flush            <= 1'b0;
         flush_pc         <= '0;
         mispredict_count <= '0;
      end else begin
         flush <= mispredict;
         if (mispredict) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            flush_pc <= resolve_next_pc;
            if (mispredict_count != '1)
               mispredict_count <= mispredict_count + 16'd1;
         end else begin
            if (push)
               tail <= tail + PTR_BITS'(1);
            if (pop)
               head <= head + PTR_BITS'(1);
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bht_branch_controller.sv
// Testbench for bht_branch_controller: a vector table of per-cycle stimulus with
// expected combinational outputs, plus a scoreboard queue that holds the
// registered outputs expected after each clock edge.
module tb_bht_branch_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic [15:0] ir;
   logic [15:0] pc;
   logic        fetch_ready;
   logic        sel_branch_predict;
   logic [15:0] branch_target;
   logic        resolve_valid;
   logic        resolve_taken;
   logic [15:0] resolve_next_pc;
   logic        flush;
   logic [15:0] flush_pc;
   logic [15:0] mispredict_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rst;
      logic        fv;
      logic [15:0] ir;
      logic [15:0] pc;
      logic        rv;
      logic        rt;
      logic [15:0] rnpc;
      logic        e_ready;
      logic        e_sel;
      logic [15:0] e_tgt;
      logic        e_flush;
      logic [15:0] e_fpc;
      logic [15:0] e_cnt;
   } vec_t;

   typedef struct {
      int          step;
      logic        flush;
      logic [15:0] fpc;
      logic        chk_fpc;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[27];

   bht_branch_controller #(.IDX_BITS(5), .DEPTH(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .fetch_valid        (fetch_valid),
      .ir                 (ir),
      .pc                 (pc),
      .fetch_ready        (fetch_ready),
      .sel_branch_predict (sel_branch_predict),
      .branch_target      (branch_target),
      .resolve_valid      (resolve_valid),
      .resolve_taken      (resolve_taken),
      .resolve_next_pc    (resolve_next_pc),
      .flush              (flush),
      .flush_pc           (flush_pc),
      .mispredict_count   (mispredict_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int step, input logic [15:0] got,
                      input logic [15:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s step %0d: got %h want %h", name, step, got, want);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic fv, input logic [15:0] i,
                               input logic [15:0] p, input logic rv, input logic rt,
                               input logic [15:0] rnpc, input logic er, input logic es,
                               input logic [15:0] et, input logic ef,
                               input logic [15:0] efpc, input logic [15:0] ecnt);
      vec_t v;
      v.rst = rst; v.fv = fv; v.ir = i; v.pc = p;
      v.rv = rv; v.rt = rt; v.rnpc = rnpc;
      v.e_ready = er; v.e_sel = es; v.e_tgt = et;
      v.e_flush = ef; v.e_fpc = efpc; v.e_cnt = ecnt;
      return v;
   endfunction

   // Drive one cycle: check combinational outputs mid-cycle, queue the registered
   // expectation, then compare it once the edge has produced it.
   task automatic run_step(input int step, input vec_t v);
      exp_t e;
      reset           = v.rst;
      fetch_valid     = v.fv;
      ir              = v.ir;
      pc              = v.pc;
      resolve_valid   = v.rv;
      resolve_taken   = v.rt;
      resolve_next_pc = v.rnpc;
      e.step    = step;
      e.flush   = v.e_flush;
      e.fpc     = v.e_fpc;
      e.chk_fpc = v.e_flush | v.rst;
      e.cnt     = v.e_cnt;
      sb.push_back(e);
      #4;
      chk("fetch_ready", step, {15'd0, fetch_ready}, {15'd0, v.e_ready});
      chk("sel_branch_predict", step, {15'd0, sel_branch_predict}, {15'd0, v.e_sel});
      chk("branch_target", step, branch_target, v.e_tgt);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard step %0d: got empty want entry", step);
      end else begin
         e = sb.pop_front();
         chk("flush", e.step, {15'd0, flush}, {15'd0, e.flush});
         if (e.chk_fpc)
            chk("flush_pc", e.step, flush_pc, e.fpc);
         chk("mispredict_count", e.step, mispredict_count, e.cnt);
      end
   endtask

   initial begin
      vec_t h;

      // Train idx 0 from weakly not-taken: first mispredict, then correct predictions
      vecs[0]  = mk(0, 1, 16'h0405, 16'h3000, 0, 0, 16'h0000, 1, 0, 16'h300A, 0, 16'h0000, 16'd0);
      vecs[1]  = mk(0, 0, 16'h0405, 16'h3000, 1, 1, 16'h300A, 1, 0, 16'h300A, 1, 16'h300A, 16'd1);
      vecs[2]  = mk(0, 1, 16'h0405, 16'h3000, 0, 0, 16'h0000, 0, 0, 16'h300A, 0, 16'h0000, 16'd1);
      vecs[3]  = mk(0, 1, 16'h0405, 16'h3000, 0, 0, 16'h0000, 1, 1, 16'h300A, 0, 16'h0000, 16'd1);
      vecs[4]  = mk(0, 0, 16'h0405, 16'h3000, 1, 1, 16'h300A, 1, 0, 16'h300A, 0, 16'h0000, 16'd1);
      vecs[5]  = mk(0, 1, 16'h0405, 16'h3000, 0, 0, 16'h0000, 1, 1, 16'h300A, 0, 16'h0000, 16'd1);
      vecs[6]  = mk(0, 0, 16'h0405, 16'h3000, 1, 1, 16'h300A, 1, 0, 16'h300A, 0, 16'h0000, 16'd1);
      // Unconditional BRnzp at an untrained index predicts taken
      vecs[7]  = mk(0, 1, 16'h0E05, 16'h3010, 0, 0, 16'h0000, 1, 1, 16'h301A, 0, 16'h0000, 16'd1);
      vecs[8]  = mk(0, 0, 16'h0E05, 16'h3010, 1, 1, 16'h301A, 1, 0, 16'h301A, 0, 16'h0000, 16'd1);
      // nzp=000 is not a branch; negative offset; 16-bit wrap of the target add
      vecs[9]  = mk(0, 1, 16'h0005, 16'h3020, 0, 0, 16'h0000, 1, 0, 16'h302A, 0, 16'h0000, 16'd1);
      vecs[10] = mk(0, 0, 16'h05FF, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'hFFFE, 0, 16'h0000, 16'd1);
      vecs[11] = mk(0, 0, 16'h02FF, 16'hFFFE, 0, 0, 16'h0000, 1, 0, 16'h01FC, 0, 16'h0000, 16'd1);
      // Fill the queue, block the fifth push, pop with a pending push, then accept it
      vecs[12] = mk(0, 1, 16'h0405, 16'h3002, 0, 0, 16'h0000, 1, 0, 16'h300C, 0, 16'h0000, 16'd1);
      vecs[13] = mk(0, 1, 16'h0405, 16'h3004, 0, 0, 16'h0000, 1, 0, 16'h300E, 0, 16'h0000, 16'd1);
      vecs[14] = mk(0, 1, 16'h0405, 16'h3006, 0, 0, 16'h0000, 1, 0, 16'h3010, 0, 16'h0000, 16'd1);
      vecs[15] = mk(0, 1, 16'h0405, 16'h3008, 0, 0, 16'h0000, 1, 0, 16'h3012, 0, 16'h0000, 16'd1);
      vecs[16] = mk(0, 1, 16'h0405, 16'h300A, 0, 0, 16'h0000, 0, 0, 16'h3014, 0, 16'h0000, 16'd1);
      vecs[17] = mk(0, 1, 16'h0405, 16'h300A, 1, 0, 16'h3002, 0, 0, 16'h3014, 0, 16'h0000, 16'd1);
      vecs[18] = mk(0, 1, 16'h0405, 16'h300A, 0, 0, 16'h0000, 1, 0, 16'h3014, 0, 16'h0000, 16'd1);
      vecs[19] = mk(0, 0, 16'h0405, 16'h300A, 1, 0, 16'h3004, 0, 0, 16'h3014, 0, 16'h0000, 16'd1);
      // Mispredict with a same-cycle push; flush cycle ignores resolve; empty resolve ignored
      vecs[20] = mk(0, 1, 16'h0405, 16'h3010, 1, 1, 16'h3018, 1, 1, 16'h301A, 1, 16'h3018, 16'd2);
      vecs[21] = mk(0, 1, 16'h0405, 16'h3010, 1, 1, 16'h3008, 0, 0, 16'h301A, 0, 16'h0000, 16'd2);
      vecs[22] = mk(0, 0, 16'h0405, 16'h3010, 1, 0, 16'h5555, 1, 0, 16'h301A, 0, 16'h0000, 16'd2);
      // Reset in the cycle a mispredict resolves wins; trained counters return to 01
      vecs[23] = mk(0, 1, 16'h0405, 16'h3002, 0, 0, 16'h0000, 1, 0, 16'h300C, 0, 16'h0000, 16'd2);
      vecs[24] = mk(1, 0, 16'h0405, 16'h3002, 1, 1, 16'h300C, 1, 0, 16'h300C, 0, 16'h0000, 16'd0);
      vecs[25] = mk(0, 1, 16'h0405, 16'h3000, 0, 0, 16'h0000, 1, 0, 16'h300A, 0, 16'h0000, 16'd0);
      vecs[26] = mk(0, 0, 16'h0405, 16'h3000, 1, 0, 16'h3000, 1, 0, 16'h300A, 0, 16'h0000, 16'd0);

      reset = 1'b1; fetch_valid = 1'b0; ir = '0; pc = '0;
      resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_next_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_flush", -1, {15'd0, flush}, 16'd0);
      chk("reset_flush_pc", -1, flush_pc, 16'h0000);
      chk("reset_mispredict_count", -1, mispredict_count, 16'd0);
      chk("reset_fetch_ready", -1, {15'd0, fetch_ready}, 16'd1);
      reset = 1'b0;

      for (int i = 0; i < 27; i++)
         run_step(i, vecs[i]);

      // Correct direction but wrong target on an unconditional BR still mispredicts
      h = mk(0, 1, 16'h0E05, 16'h3010, 0, 0, 16'h0000, 1, 1, 16'h301A, 0, 16'h0000, 16'd0);
      run_step(100, h);
      h = mk(0, 0, 16'h0E05, 16'h3010, 1, 1, 16'h3020, 1, 0, 16'h301A, 1, 16'h3020, 16'd1);
      run_step(101, h);
      h = mk(0, 0, 16'h0E05, 16'h3010, 0, 0, 16'h0000, 0, 0, 16'h301A, 0, 16'h0000, 16'd1);
      run_step(102, h);
      h = mk(0, 0, 16'h0E05, 16'h3010, 0, 0, 16'h0000, 1, 0, 16'h301A, 0, 16'h0000, 16'd1);
      run_step(103, h);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
